// File: rtl/day12_job_sequencer.sv
// Day 12 job sequencer: parses header and length-prefixed frames,
// feeds payloads to the accelerator and returns the fit total.
module day12_job_sequencer #(
  parameter int MAX_FRAME_WORDS = 4096,
  parameter int TIMEOUT_CYCLES  = 65535,
  parameter int CNT_W           = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  output logic        acc_in_valid,
  output logic [31:0] acc_in_data,
  input  logic        acc_in_ready,
  input  logic        acc_out_valid,
  input  logic [31:0] acc_out_data,
  output logic        acc_out_ready,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LEN, FWD, WAIT_RES, DONE
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] remaining, remaining_nx;
  logic [CNT_W-1:0] fit_count, fit_nx;
  logic             err, err_nx;
  logic [12:0]      wcnt, wcnt_nx;
  logic [TW-1:0]    timer, timer_nx;
  logic [12:0]      len_w, len_c;
  logic             unused_verdict_bits;

  assign unused_verdict_bits = ^acc_out_data[31:1];
  assign acc_out_ready = 1'b1;
  assign busy = (state != IDLE);

  assign len_w = s_data[12:0];
  assign len_c = (len_w > 13'(MAX_FRAME_WORDS)) ?
                 13'(MAX_FRAME_WORDS) : len_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      fit_count <= '0;
      err       <= 1'b0;
      wcnt      <= '0;
      timer     <= '0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      fit_count <= fit_nx;
      err       <= err_nx;
      wcnt      <= wcnt_nx;
      timer     <= timer_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    fit_nx       = fit_count;
    err_nx       = err;
    wcnt_nx      = wcnt;
    timer_nx     = timer;
    s_ready      = 1'b0;
    acc_in_valid = 1'b0;
    acc_in_data  = '0;
    m_valid      = 1'b0;
    m_data       = '0;
    unique case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          remaining_nx = s_data[CNT_W-1:0];
          fit_nx       = '0;
          err_nx       = 1'b0;
          state_nx     = (s_data[CNT_W-1:0] == '0) ? DONE : LEN;
        end
      end
      LEN: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (len_c == '0) begin
            // empty region: not-fit, nothing sent to the accelerator
            remaining_nx = remaining - 1'b1;
            if (remaining == CNT_W'(1)) state_nx = DONE;
          end else begin
            wcnt_nx  = len_c;
            state_nx = FWD;
          end
        end
      end
      FWD: begin
        acc_in_valid = s_valid;
        acc_in_data  = s_data;
        s_ready      = acc_in_ready;
        if (s_valid && acc_in_ready) begin
          wcnt_nx = wcnt - 1'b1;
          if (wcnt == 13'd1) begin
            state_nx = WAIT_RES;
            timer_nx = '0;
          end
        end
      end
      WAIT_RES: begin
        timer_nx = timer + 1'b1;
        // a verdict in the timeout cycle still counts
        if (acc_out_valid || timer == TW'(TIMEOUT_CYCLES - 1)) begin
          if (acc_out_valid) begin
            if (fit_count != '1)
              fit_nx = fit_count + CNT_W'(acc_out_data[0]);
          end else begin
            err_nx = 1'b1;
          end
          remaining_nx = remaining - 1'b1;
          state_nx = (remaining == CNT_W'(1)) ? DONE : LEN;
        end
      end
      DONE: begin
        m_valid              = 1'b1;
        m_data[CNT_W-1:0]    = fit_count;
        m_data[31]           = err;
        if (m_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
